alu_op_sequencer: RTL and testbench

- Hardwired control sequencer for the single-bus CPU datapath; replaces hand-driven T-state control with an FSM.
- Fetches an instruction in T0–T2, decodes the opcode class, then drives execute states T3–T6 for three classes: unary (neg/not), binary register-register, and mul/div with HI/LO writeback.
- Generalises the negate-only flow to any register count and opcode class.

---
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: control/strobe bundle between the sequencer (slave) and the datapath side (master).
interface alu_op_sequencer_if #(
  parameter int REG_SEL_W = 4,
  parameter int OPCODE_W  = 5
);
  logic                 Run, MemReady;
  logic [31:0]          IR;
  logic                 PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic                 ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
  logic                 RegOut, RegIn, Busy, Done, IllegalOp;
  logic [REG_SEL_W-1:0] RegOutSel, RegInSel;
  logic [OPCODE_W-1:0]  AluOp;
  modport slave (
    input  Run, IR, MemReady,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
           ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
           RegOut, RegOutSel, RegIn, RegInSel, AluOp, Busy, Done, IllegalOp
  );
  modport master (
    output Run, IR, MemReady,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
           ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
           RegOut, RegOutSel, RegIn, RegInSel, AluOp, Busy, Done, IllegalOp
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetch/decode/execute control FSM for the single-bus CPU datapath.
// Optional SEQ_MEM_WAIT_EN: T1 repeats until MemReady, PCin/Zlowout only in the final T1 cycle.
module alu_op_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int REG_SEL_W = 4,
  parameter int OPCODE_W  = 5
) (
  input logic Clock,
  input logic Clear,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;
  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in, reg_out, reg_in, done, illegal;
    logic [REG_SEL_W-1:0] out_sel, in_sel;
    logic [OPCODE_W-1:0] alu_op;
  } ctl_t;
  state_t state_q, state_d;
  ctl_t ctl_q, ctl_d;
  logic [16:0] ir_q, ir_cur;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic is_bin, is_md, is_un, legal;
  function automatic logic reg_ok(input logic [3:0] r);
    return int'(r) < NUM_REGS;
  endfunction
  // In T2 the IR being latched is decoded directly; later states use the captured copy
  assign ir_cur = (state_q == T2) ? bus.IR[31:15] : ir_q;
  assign op = ir_cur[16:12];
  assign ra = ir_cur[11:8];
  assign rb = ir_cur[7:4];
  assign rc = ir_cur[3:0];
  assign is_bin = op >= 5'h03 && op <= 5'h0B;
  assign is_md = op == 5'h0E || op == 5'h0F;
  assign is_un = op == 5'h10 || op == 5'h11;
  assign legal = (is_bin || is_md || is_un) && reg_ok(ra) && reg_ok(rb) && (!is_bin || reg_ok(rc));
  always_ff @(posedge Clock) begin
    state_q <= Clear ? IDLE : state_d;
    ctl_q <= Clear ? '0 : ctl_d;
    ir_q <= Clear ? '0 : (state_q == T2 ? bus.IR[31:15] : ir_q);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.Run ? T0 : IDLE;
      T0: state_d = T1;
`ifdef SEQ_MEM_WAIT_EN
      T1: state_d = bus.MemReady ? T2 : T1;
`else
      T1: state_d = T2;
`endif
      T2: state_d = legal ? T3 : DONE;
      T3: state_d = T4;
      T4: state_d = is_un ? DONE : T5;
      T5: state_d = is_md ? T6 : DONE;
      T6: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ctl_d = '0;
    case (state_d)
      T0: begin
        ctl_d.pc_out = 1'b1;
        ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1;
        ctl_d.zlo_in = 1'b1;
      end
      T1: begin
        ctl_d.zlo_out = 1'b1;
        ctl_d.pc_in = 1'b1;
        ctl_d.read = 1'b1;
        ctl_d.mdr_in = 1'b1;
      end
      T2: begin
        ctl_d.mdr_out = 1'b1;
        ctl_d.ir_in = 1'b1;
      end
      T3: begin
        ctl_d.reg_out = 1'b1;
        ctl_d.out_sel = REG_SEL_W'(is_md ? ra : rb);
        ctl_d.y_in = !is_un;
        ctl_d.alu_op = is_un ? OPCODE_W'(op) : '0;
        ctl_d.zlo_in = is_un;
        ctl_d.zhi_in = is_un;
      end
      T4: begin
        ctl_d.zlo_out = is_un;
        ctl_d.reg_in = is_un;
        ctl_d.in_sel = is_un ? REG_SEL_W'(ra) : '0;
        ctl_d.reg_out = !is_un;
        ctl_d.out_sel = is_un ? '0 : REG_SEL_W'(is_md ? rb : rc);
        ctl_d.alu_op = is_un ? '0 : OPCODE_W'(op);
        ctl_d.zlo_in = !is_un;
        ctl_d.zhi_in = !is_un;
      end
      T5: begin
        ctl_d.zlo_out = 1'b1;
        ctl_d.lo_in = is_md;
        ctl_d.reg_in = !is_md;
        ctl_d.in_sel = is_md ? '0 : REG_SEL_W'(ra);
      end
      T6: begin
        ctl_d.zhi_out = 1'b1;
        ctl_d.hi_in = 1'b1;
      end
      DONE: begin
        ctl_d.done = 1'b1;
        ctl_d.illegal = state_q == T2;
      end
      default: ctl_d = '0;
    endcase
  end
`ifdef SEQ_MEM_WAIT_EN
  logic t1_last;
  assign t1_last = state_q != T1 || bus.MemReady;
  assign bus.PCin = ctl_q.pc_in & t1_last;
  assign bus.Zlowout = ctl_q.zlo_out & t1_last;
`else
  assign bus.PCin = ctl_q.pc_in;
  assign bus.Zlowout = ctl_q.zlo_out;
`endif
  assign bus.PCout = ctl_q.pc_out;
  assign bus.MARin = ctl_q.mar_in;
  assign bus.IncPC = ctl_q.inc_pc;
  assign bus.Read = ctl_q.read;
  assign bus.MDRin = ctl_q.mdr_in;
  assign bus.MDRout = ctl_q.mdr_out;
  assign bus.IRin = ctl_q.ir_in;
  assign bus.Yin = ctl_q.y_in;
  assign bus.ZLowIn = ctl_q.zlo_in;
  assign bus.ZHighIn = ctl_q.zhi_in;
  assign bus.ZHighout = ctl_q.zhi_out;
  assign bus.HIin = ctl_q.hi_in;
  assign bus.LOin = ctl_q.lo_in;
  assign bus.RegOut = ctl_q.reg_out;
  assign bus.RegOutSel = ctl_q.out_sel;
  assign bus.RegIn = ctl_q.reg_in;
  assign bus.RegInSel = ctl_q.in_sel;
  assign bus.AluOp = ctl_q.alu_op;
  assign bus.Done = ctl_q.done;
  assign bus.IllegalOp = ctl_q.illegal;
  assign bus.Busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized scoreboard bench; a per-instruction model predicts latency and bus activity.
module tb_alu_op_sequencer;
  localparam int NR = 12;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  alu_op_sequencer_if ifc ();
  alu_op_sequencer #(.NUM_REGS(NR)) dut (.Clock(clk), .Clear(clr), .bus(ifc));
  typedef struct {
    int lat, ill, rin, rin_sel, lo, hi, alu, nsel, sel0, sel1, conf, nbusy;
  } rsp_t;
  rsp_t exp_q[$];
  int n_chk = 0, n_pass = 0, regin_total = 0;
  logic [32:0] outs;
  assign outs = {ifc.PCout, ifc.MARin, ifc.IncPC, ifc.PCin, ifc.Read, ifc.MDRin, ifc.MDRout,
                 ifc.IRin, ifc.Yin, ifc.ZLowIn, ifc.ZHighIn, ifc.Zlowout, ifc.ZHighout, ifc.HIin,
                 ifc.LOin, ifc.RegOut, ifc.RegIn, ifc.Done, ifc.IllegalOp, ifc.RegOutSel,
                 ifc.RegInSel, ifc.AluOp};
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic rsp_t model(input logic [31:0] ir);
    rsp_t r = '{default: 0};
    int op = int'(ir[31:27]), ra = int'(ir[26:23]), rb = int'(ir[22:19]), rc = int'(ir[18:15]);
    bit un = op == 16 || op == 17;
    bit bin = op >= 3 && op <= 11;
    bit md = op == 14 || op == 15;
    if (!(un || bin || md) || ra >= NR || rb >= NR || (bin && rc >= NR)) begin
      r.lat = 4;
      r.ill = 1;
      return r;
    end
    r.alu = op;
    if (un) begin
      r.lat = 6; r.rin = 1; r.rin_sel = ra; r.nsel = 1; r.sel0 = rb;
    end else if (bin) begin
      r.lat = 7; r.rin = 1; r.rin_sel = ra; r.nsel = 2; r.sel0 = rb; r.sel1 = rc;
    end else begin
      r.lat = 8; r.lo = 1; r.hi = 1; r.nsel = 2; r.sel0 = ra; r.sel1 = rb;
    end
    return r;
  endfunction
  // Monitor: collects what one instruction did from its T0 to its Done pulse
  bit active = 0;
  rsp_t obs, e;
  always @(negedge clk) begin
    if (ifc.RegIn) regin_total++;
    if (clr) active = 0;
    else begin
      if (ifc.PCout && ifc.MARin) begin
        active = 1;
        obs = '{default: 0};
      end
      if (active) begin
        obs.lat++;
        if (int'(ifc.PCout) + int'(ifc.MDRout) + int'(ifc.Zlowout) + int'(ifc.ZHighout) + int'(ifc.RegOut) > 1) obs.conf++;
        if (!ifc.Busy) obs.nbusy++;
        if (ifc.RegOut) begin
          if (obs.nsel == 0) obs.sel0 = int'(ifc.RegOutSel);
          else obs.sel1 = int'(ifc.RegOutSel);
          obs.nsel++;
        end
        if (ifc.RegIn) begin
          obs.rin++;
          obs.rin_sel = int'(ifc.RegInSel);
        end
        if (ifc.LOin) obs.lo++;
        if (ifc.HIin) obs.hi++;
        if (ifc.AluOp != 0) obs.alu = int'(ifc.AluOp);
        if (ifc.Done) begin
          obs.ill = int'(ifc.IllegalOp);
          active = 0;
          if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("latency", obs.lat, e.lat);
            chk("illegal", obs.ill, e.ill);
            chk("regin_count", obs.rin, e.rin);
            chk("regin_sel", obs.rin_sel, e.rin_sel);
            chk("lo_count", obs.lo, e.lo);
            chk("hi_count", obs.hi, e.hi);
            chk("aluop", obs.alu, e.alu);
            chk("regout_count", obs.nsel, e.nsel);
            chk("regout_sel0", obs.sel0, e.sel0);
            chk("regout_sel1", obs.sel1, e.sel1);
            chk("bus_conflict", obs.conf, 0);
            chk("busy_low", obs.nbusy, 0);
          end
        end
      end
    end
  end
`ifdef SEQ_MEM_WAIT_EN
  initial ifc.MemReady = 1'b1;
`else
  initial forever begin
    ifc.MemReady = 1'($urandom);
    @(negedge clk);
  end
`endif
  task automatic issue(input logic [31:0] ir, input int gap, input bit hold, input bit track);
    int w = 0;
    if (gap > 0) begin
      ifc.Run = 1'b0;
      repeat (gap) @(negedge clk);
    end
    ifc.IR = ir;
    ifc.Run = 1'b1;
    if (track) exp_q.push_back(model(ir));
    do begin
      @(negedge clk);
      w++;
    end while (!ifc.PCout && w < 10);
    chk("t0_start", w, 1);
    ifc.Run = hold;
    if (!track) return;
    w = 0;
    while (!ifc.Done && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ifc.Done) chk("done_timeout", 0, 1);
  endtask
  initial begin
    logic [31:0] ir;
    logic [4:0] op;
    int w, rb0, k;
    ifc.Run = 1'b0;
    ifc.IR = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(|outs), 0);
    chk("reset_busy", int'(ifc.Busy), 0);
    clr = 1'b0;
    @(negedge clk);
    issue(32'h82900000, 0, 0, 1);
    issue(32'h1A920000, 1, 0, 1);
    issue(32'h71100000, 2, 0, 1);
    issue(32'hF8000000, 1, 1, 1);
    issue((32'd3 << 27) | (32'd13 << 23), 0, 1, 1);
    issue(32'h1A920000, 0, 0, 1);
    issue(32'h1A920000, 2, 0, 0);
    w = 0;
    while (!(ifc.ZLowIn && ifc.RegOut) && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("reach_t4", int'(ifc.ZLowIn && ifc.RegOut), 1);
    rb0 = regin_total;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("clear_outputs", int'(|outs), 0);
    chk("clear_busy", int'(ifc.Busy), 0);
    @(negedge clk);
    chk("clear_no_regin", regin_total - rb0, 0);
    chk("clear_stays_idle", int'(ifc.Busy), 0);
    issue(32'h82900000, 0, 0, 1);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      op = k < 3 ? 5'(16 + $urandom_range(0, 1)) : k < 6 ? 5'(3 + $urandom_range(0, 8)) :
           k < 8 ? 5'(14 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      ir = {op, 27'($urandom)};
      issue(ir, $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 3), 1'($urandom), 1);
    end
    ifc.Run = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_idle", int'(ifc.Busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
